wb_arb2: RTL and testbench
==========================

# wb_arb2

Two-master Wishbone arbiter that shares one Wishbone slave, normally the `wb_ram` single-port RAM, between the Selen instruction-fetch port (m0) and data port (m1). It does round-robin arbitration at bus-cycle granularity. A grant is held for as long as the granted master keeps `cyc` asserted. Slave responses are routed back only to the granted master. The block sits between the core's two bus interfaces and the RAM.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width (`DW/8` byte selects)
- `TO_CYCLES`, 16, watchdog limit in cycles (used only when `WB_ARB_TIMEOUT_EN` is defined; must be ≥ 2)

Ports:
- Clocking: one clock; reset is synchronous and active-high.
  - `wb_clk_i`  in  1  clock; all state changes on its rising edge
  - `wb_rst_i`  in  1  synchronous, active-high reset
- Master ports, for n = 0, 1:
  - `mN_wb_adr_i`  in  AW  address
  - `mN_wb_dat_i`  in  DW  write data
  - `mN_wb_sel_i`  in  DW/8  byte selects
  - `mN_wb_we_i`  in  1  write enable
  - `mN_wb_cyc_i`  in  1  bus cycle
  - `mN_wb_stb_i`  in  1  strobe
  - `mN_wb_dat_o`  out  DW  read data
  - `mN_wb_ack_o`  out  1  acknowledge
  - `mN_wb_err_o`  out  1  error
- Slave port:
  - `s_wb_adr_o`, `s_wb_dat_o`, `s_wb_sel_o`, `s_wb_we_o`, `s_wb_cyc_o`, `s_wb_stb_o`  out  muxed request, widths as the master inputs
  - `s_wb_dat_i`  in  DW  read data
  - `s_wb_ack_i`  in  1  acknowledge
  - `s_wb_err_i`  in  1  error

## Operation
- States: `IDLE`, `G0` (m0 owns the slave), `G1` (m1 owns the slave). One-bit `last` register records the most recent grant.
- `IDLE` transitions:
  - only m0 cyc → `G0`
  - only m1 cyc → `G1`
  - both → the master ≠ `last`
  - neither → stay in `IDLE`
- `Gn` transitions:
  - while `mN_wb_cyc_i`=1 → stay
  - when it drops: if the other master's cyc=1 → go directly to the other grant (no idle cycle); otherwise → `IDLE`
  - `last` updates on every entry to `Gn`.
- Request mux (combinational from state):
  - in `Gn`, all `s_wb_*_o` equal master n's inputs
  - in `IDLE`, `s_wb_cyc_o` = `s_wb_stb_o` = 0, and the other slave outputs follow m0
- Response routing:
  - `s_wb_dat_i` is broadcast to both `mN_wb_dat_o`
  - `mN_wb_ack_o` = `s_wb_ack_i` & (state==`Gn`)
  - `mN_wb_err_o` = `s_wb_err_i` & (state==`Gn`), OR'd with the watchdog error when the watchdog is built
  - the non-granted master never sees ack or err
- Dropping cyc forces a regrant. A master issuing back-to-back cycles with cyc held continuously keeps the grant; fairness applies only at cyc boundaries.

## Timing
- Reset values: state=`IDLE`, `last`=1 (m0 wins the first tie), watchdog counter=0. From reset onward all `mN_wb_ack_o`/`mN_wb_err_o`=0 and `s_wb_cyc_o`/`s_wb_stb_o`=0.
- Grant latency: cyc asserted in cycle T → grant state from edge T+1 → slave sees the request in T+1. With `wb_ram` (registered ack), the master's ack arrives in cycle T+2.
- Handoff: m0 drops cyc in cycle T with m1 requesting → `G1` from T+1.
- Reset during a transfer: state goes to `IDLE` at that edge, and any slave ack arriving afterwards is discarded.
- Simultaneous cyc-drop and ack by the granted master: the ack is delivered in that cycle (state is still `Gn`).

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - a counter of width `$clog2(TO_CYCLES+1)` increments each cycle in `Gn` with stb=1 and no slave ack/err
  - it clears on ack, err, or a state change
  - when it reaches `TO_CYCLES`, `mN_wb_err_o` pulses for exactly one cycle, the counter clears, and `s_wb_stb_o` is masked to 0 in that cycle
- `WB_ARB_TIMEOUT_EN` undefined: no counter; err comes from the slave only.

## Test plan
- Single m0 read at addr 0x10 after reset → `s_wb_cyc_o` rises one cycle after m0 cyc; `m0_wb_ack_o` two cycles after cyc; `m1_wb_ack_o` stays 0.
- m0 and m1 raise cyc in the same cycle → m0 is granted first; after m0 drops cyc, m1 is granted on the next edge with no idle cycle; the next tie goes to m0 again.
- m1 holds cyc for 4 back-to-back writes (data 0xA5A5_0001..4) while m0 waits → all four reach the slave; m0 is granted only after m1 drops cyc; memory readback matches.
- `wb_rst_i` asserted in the cycle after a grant → slave cyc/stb are 0 from the next edge; the stale ack is not forwarded; state is `IDLE`.
- Macro defined, `TO_CYCLES`=16, slave never acks → `m0_wb_err_o` pulses exactly once, 16 cycles after the grant; grant is retained while cyc=1.
- Slave `s_wb_err_i`=1 during a m1 access → `m1_wb_err_o`=1 in the same cycle and `m0_wb_err_o`=0.

Source files
------------

// File: rtl/wb_arb2.sv
// wb_arb2: two-master Wishbone arbiter, round-robin at cyc boundaries.
// Optional watchdog error enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arb2 #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TO_CYCLES = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   m0_wb_adr_i,
  input  logic [DW-1:0]   m0_wb_dat_i,
  input  logic [DW/8-1:0] m0_wb_sel_i,
  input  logic            m0_wb_we_i,
  input  logic            m0_wb_cyc_i,
  input  logic            m0_wb_stb_i,
  output logic [DW-1:0]   m0_wb_dat_o,
  output logic            m0_wb_ack_o,
  output logic            m0_wb_err_o,
  input  logic [AW-1:0]   m1_wb_adr_i,
  input  logic [DW-1:0]   m1_wb_dat_i,
  input  logic [DW/8-1:0] m1_wb_sel_i,
  input  logic            m1_wb_we_i,
  input  logic            m1_wb_cyc_i,
  input  logic            m1_wb_stb_i,
  output logic [DW-1:0]   m1_wb_dat_o,
  output logic            m1_wb_ack_o,
  output logic            m1_wb_err_o,
  output logic [AW-1:0]   s_wb_adr_o,
  output logic [DW-1:0]   s_wb_dat_o,
  output logic [DW/8-1:0] s_wb_sel_o,
  output logic            s_wb_we_o,
  output logic            s_wb_cyc_o,
  output logic            s_wb_stb_o,
  input  logic [DW-1:0]   s_wb_dat_i,
  input  logic            s_wb_ack_i,
  input  logic            s_wb_err_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   gnt0, gnt1;
  logic   to_hit;

  assign gnt0 = (state_q == G0);
  assign gnt1 = (state_q == G1);

  // Next grant: hold while owner keeps cyc, hand off directly, else idle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_wb_cyc_i && m1_wb_cyc_i)
          state_d = last_q ? G0 : G1;
        else if (m0_wb_cyc_i)
          state_d = G0;
        else if (m1_wb_cyc_i)
          state_d = G1;
      end
      G0: begin
        if (!m0_wb_cyc_i)
          state_d = m1_wb_cyc_i ? G1 : IDLE;
      end
      G1: begin
        if (!m1_wb_cyc_i)
          state_d = m0_wb_cyc_i ? G0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == G0 && state_q != G0)
      last_d = 1'b0;
    else if (state_d == G1 && state_q != G1)
      last_d = 1'b1;
  end

  // Grant state and round-robin history; last=1 lets m0 win the first tie.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt_stb;

  assign gnt_stb = (gnt0 && m0_wb_stb_i) || (gnt1 && m1_wb_stb_i);
  assign to_hit  = (state_q != IDLE) && (cnt_q == CW'(TO_CYCLES));

  // Watchdog counts stalled strobe cycles of the current owner.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE || state_d != state_q ||
        s_wb_ack_i || s_wb_err_i || to_hit)
      cnt_d = '0;
    else if (gnt_stb)
      cnt_d = cnt_q + 1'b1;
  end

  // Watchdog counter register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  // Request mux: owner drives the slave; idle follows m0 with cyc/stb low.
  always_comb begin
    s_wb_adr_o = gnt1 ? m1_wb_adr_i : m0_wb_adr_i;
    s_wb_dat_o = gnt1 ? m1_wb_dat_i : m0_wb_dat_i;
    s_wb_sel_o = gnt1 ? m1_wb_sel_i : m0_wb_sel_i;
    s_wb_we_o  = gnt1 ? m1_wb_we_i  : m0_wb_we_i;
    s_wb_cyc_o = (gnt0 && m0_wb_cyc_i) || (gnt1 && m1_wb_cyc_i);
    s_wb_stb_o = ((gnt0 && m0_wb_stb_i) || (gnt1 && m1_wb_stb_i)) && !to_hit;
  end

  // Responses go only to the owner; read data is shared.
  always_comb begin
    m0_wb_dat_o = s_wb_dat_i;
    m1_wb_dat_o = s_wb_dat_i;
    m0_wb_ack_o = s_wb_ack_i && gnt0;
    m1_wb_ack_o = s_wb_ack_i && gnt1;
    m0_wb_err_o = gnt0 && (s_wb_err_i || to_hit);
    m1_wb_err_o = gnt1 && (s_wb_err_i || to_hit);
  end

endmodule

// File: tb/tb_wb_arb2.sv
// tb_wb_arb2: directed bench for wb_arb2 with a registered-ack RAM model.
// Read data is checked through an expected-value queue.
module tb_wb_arb2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
  logic [31:0] m0_rd, m1_rd;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] s_adr, s_wdat;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb;
  logic [31:0] s_rdat;
  logic        s_ack;
  logic        s_err;
  logic        mute;

  logic [31:0] mem [256];
  logic [31:0] exp_q [$];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  wb_arb2 #(.AW(32), .DW(32), .TO_CYCLES(16)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .m0_wb_adr_i (m0_adr),
    .m0_wb_dat_i (m0_dat),
    .m0_wb_sel_i (m0_sel),
    .m0_wb_we_i  (m0_we),
    .m0_wb_cyc_i (m0_cyc),
    .m0_wb_stb_i (m0_stb),
    .m0_wb_dat_o (m0_rd),
    .m0_wb_ack_o (m0_ack),
    .m0_wb_err_o (m0_err),
    .m1_wb_adr_i (m1_adr),
    .m1_wb_dat_i (m1_dat),
    .m1_wb_sel_i (m1_sel),
    .m1_wb_we_i  (m1_we),
    .m1_wb_cyc_i (m1_cyc),
    .m1_wb_stb_i (m1_stb),
    .m1_wb_dat_o (m1_rd),
    .m1_wb_ack_o (m1_ack),
    .m1_wb_err_o (m1_err),
    .s_wb_adr_o  (s_adr),
    .s_wb_dat_o  (s_wdat),
    .s_wb_sel_o  (s_sel),
    .s_wb_we_o   (s_we),
    .s_wb_cyc_o  (s_cyc),
    .s_wb_stb_o  (s_stb),
    .s_wb_dat_i  (s_rdat),
    .s_wb_ack_i  (s_ack),
    .s_wb_err_i  (s_err)
  );

  // RAM slave with registered ack, one ack per request.
  always @(posedge clk) begin
    if (s_cyc && s_stb && !s_ack && !mute) begin
      s_ack <= 1'b1;
      if (s_we) mem[s_adr[9:2]] <= s_wdat;
      s_rdat <= mem[s_adr[9:2]];
    end else begin
      s_ack <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return 32'hC0DE_0000 | {24'd0, a[9:2]};
  endfunction

  // Wait (bounded) for master m's ack; verify isolation and read data.
  task automatic wait_ack(input int m, input bit rd, input string tag);
    bit got = 0;
    logic [31:0] e;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if ((m == 0) ? m0_ack : m1_ack) got = 1;
    end
    if (rd) e = exp_q.pop_front();
    if (!got) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s: observed no ack expected ack on m%0d", tag, m);
    end else begin
      chk({tag, "_other_ack"}, {31'd0, (m == 0) ? m1_ack : m0_ack}, 32'd0);
      if (rd) chk({tag, "_rdata"}, (m == 0) ? m0_rd : m1_rd, e);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
    s_ack = 1'b0; s_rdat = '0; s_err = 1'b0; mute = 1'b0;
    rst = 1'b1;
    m0_adr = 32'h1234; m0_dat = '0; m0_sel = 4'hF;
    m0_we = 0; m0_cyc = 0; m0_stb = 0;
    m1_adr = 32'h5678; m1_dat = '0; m1_sel = 4'hF;
    m1_we = 0; m1_cyc = 0; m1_stb = 0;
    tick();
    tick();
    chk("rst_s_cyc", {31'd0, s_cyc}, 0);
    chk("rst_s_stb", {31'd0, s_stb}, 0);
    chk("rst_acks", {30'd0, m0_ack, m1_ack}, 0);
    chk("rst_errs", {30'd0, m0_err, m1_err}, 0);
    chk("idle_mux_m0", s_adr, 32'h1234);

    // Single m0 read of 0x10.
    rst = 0;
    m0_adr = 32'h10; m0_cyc = 1; m0_stb = 1;
    #1 chk("t1_cyc_T", {31'd0, s_cyc}, 0);
    exp_q.push_back(init_val(32'h10));
    tick();
    chk("t1_cyc_T1", {31'd0, s_cyc}, 1);
    chk("t1_adr_T1", s_adr, 32'h10);
    chk("t1_ack_T1", {31'd0, m0_ack}, 0);
    tick();
    chk("t1_ack_T2", {31'd0, m0_ack}, 1);
    chk("t1_m1_ack", {31'd0, m1_ack}, 0);
    chk("t1_rdata", m0_rd, exp_q.pop_front());
    m0_cyc = 0; m0_stb = 0;
    #1 chk("t1_ack_on_drop", {31'd0, m0_ack}, 1);
    tick();
    chk("t1_idle", {31'd0, s_cyc}, 0);

    // Tie after reset: m0 first, direct handoff, next tie m0 again.
    rst = 1;
    tick();
    rst = 0;
    m0_adr = 32'h20; m0_cyc = 1; m0_stb = 1;
    m1_adr = 32'h30; m1_cyc = 1; m1_stb = 1;
    tick();
    chk("t2_first_m0", s_adr, 32'h20);
    exp_q.push_back(init_val(32'h20));
    wait_ack(0, 1, "t2_m0");
    m0_cyc = 0; m0_stb = 0;
    tick();
    chk("t2_handoff_cyc", {31'd0, s_cyc}, 1);
    chk("t2_handoff_adr", s_adr, 32'h30);
    exp_q.push_back(init_val(32'h30));
    wait_ack(1, 1, "t2_m1");
    m1_cyc = 0; m1_stb = 0;
    tick();
    chk("t2_gap_idle", {31'd0, s_cyc}, 0);
    m0_adr = 32'h24; m0_cyc = 1; m0_stb = 1;
    m1_adr = 32'h34; m1_cyc = 1; m1_stb = 1;
    tick();
    chk("t2_tie2_m0", s_adr, 32'h24);
    exp_q.push_back(init_val(32'h24));
    wait_ack(0, 1, "t2_m0b");
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    tick();

    // m1 holds cyc across four writes while m0 waits.
    m0_adr = 32'h50; m0_cyc = 1; m0_stb = 1;
    m1_adr = 32'h40; m1_dat = 32'hA5A5_0001; m1_we = 1;
    m1_cyc = 1; m1_stb = 1;
    tick();
    chk("t3_m1_wins", s_adr, 32'h40);
    chk("t3_we", {31'd0, s_we}, 1);
    for (int k = 1; k <= 4; k++) begin
      wait_ack(1, 0, "t3_wr");
      chk("t3_wr_adr", s_adr, 32'h40 + 32'(4 * (k - 1)));
      if (k < 4) begin
        m1_adr = 32'h40 + 32'(4 * k);
        m1_dat = 32'hA5A5_0000 + 32'(k + 1);
      end else begin
        m1_cyc = 0; m1_stb = 0; m1_we = 0;
      end
    end
    tick();
    chk("t3_m0_after", s_adr, 32'h50);
    exp_q.push_back(init_val(32'h50));
    wait_ack(0, 1, "t3_m0");
    for (int k = 0; k < 4; k++) begin
      m0_adr = 32'h40 + 32'(4 * k);
      exp_q.push_back(32'hA5A5_0000 + 32'(k + 1));
      wait_ack(0, 1, "t3_rb");
    end
    m0_cyc = 0; m0_stb = 0;
    tick();

    // Reset the cycle after a grant; stale ack must not reach m0.
    m0_adr = 32'h10; m0_cyc = 1; m0_stb = 1;
    tick();
    chk("t4_granted", {31'd0, s_cyc}, 1);
    rst = 1;
    tick();
    chk("t4_rst_cyc", {31'd0, s_cyc}, 0);
    chk("t4_rst_stb", {31'd0, s_stb}, 0);
    chk("t4_stale_ack", {31'd0, m0_ack}, 0);
    m0_cyc = 0; m0_stb = 0; rst = 0;
    tick();

    // Slave error during an m1 access.
    m1_adr = 32'h10; m1_cyc = 1; m1_stb = 1;
    tick();
    s_err = 1;
    #1 chk("t6_m1_err", {31'd0, m1_err}, 1);
    chk("t6_m0_err", {31'd0, m0_err}, 0);
    s_err = 0;
    m1_cyc = 0; m1_stb = 0;
    tick();
    chk("t6_after_ack0", {31'd0, m1_ack}, 0);
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    // Silent slave: one watchdog error 16 cycles after the grant.
    begin
      int pulses = 0;
      int first = -1;
      mute = 1;
      m0_adr = 32'h10; m0_cyc = 1; m0_stb = 1;
      tick();
      for (int i = 0; i < 30; i++) begin
        if (m0_err) begin
          pulses++;
          if (first < 0) first = i;
          chk("t5_stb_masked", {31'd0, s_stb}, 0);
        end
        tick();
      end
      chk("t5_pulses", 32'(pulses), 1);
      chk("t5_delay", 32'(first), 16);
      chk("t5_grant_held", {31'd0, s_cyc}, 1);
      m0_cyc = 0; m0_stb = 0; mute = 0;
      tick();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
